apb_master_bridge: RTL

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge.sv | 121 ++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// Single-outstanding command-to-APB master bridge.
// It includes an ACCESS wait timeout and a held response handshake.
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      apb_clk_in,
  input  logic                      apb_rst_in,
  // command
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic                      cmd_write_in,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_in,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_in,
  // response
  output logic                      rsp_valid_out,
  input  logic                      rsp_ready_in,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_out,
  output logic                      rsp_slverr_out,
  output logic                      rsp_timeout_out,
  // APB
  output logic [APB_ADDR_WIDTH-1:0] apb_addr_out,
  output logic                      apb_psel_out,
  output logic                      apb_penable_out,
  output logic                      apb_write_out,
  output logic [APB_DATA_WIDTH-1:0] apb_wdata_out,
  input  logic [APB_DATA_WIDTH-1:0] apb_rdata_in,
  input  logic                      apb_ready_in,
  input  logic                      apb_slverr_in
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      slverr;
    logic                      timeout;
  } rsp_t;

  localparam logic [7:0] TMO    = 8'(TIMEOUT_CYCLES);
  localparam bit         TMO_EN = (TIMEOUT_CYCLES != 0);

  state_t     state;
  logic [7:0] wait_cnt;
  rsp_t       rsp_q;

  assign rsp_rdata_out   = rsp_q.rdata;
  assign rsp_slverr_out  = rsp_q.slverr;
  assign rsp_timeout_out = rsp_q.timeout;

  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      cmd_ready_out   <= 1'b0;
      rsp_valid_out   <= 1'b0;
      rsp_q           <= '0;
      apb_addr_out    <= '0;
      apb_psel_out    <= 1'b0;
      apb_penable_out <= 1'b0;
      apb_write_out   <= 1'b0;
      apb_wdata_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready_out <= 1'b1;
          if (cmd_valid_in && cmd_ready_out) begin
            cmd_ready_out <= 1'b0;
            // Misaligned commands are answered locally; the APB bus never sees them.
            if (cmd_addr_in[1:0] != 2'b00) begin
              state         <= RESP;
              rsp_valid_out <= 1'b1;
              rsp_q         <= '{rdata: '0, slverr: 1'b1, timeout: 1'b0};
            end else begin
              state         <= SETUP;
              wait_cnt      <= '0;
              apb_psel_out  <= 1'b1;
              apb_addr_out  <= cmd_addr_in;
              apb_write_out <= cmd_write_in;
              apb_wdata_out <= cmd_wdata_in;
            end
          end
        end
        SETUP: begin
          state           <= ACCESS;
          apb_penable_out <= 1'b1;
        end
        ACCESS: begin
          // A ready on the timeout edge still completes normally.
          if (apb_ready_in) begin
            state           <= RESP;
            apb_psel_out    <= 1'b0;
            apb_penable_out <= 1'b0;
            rsp_valid_out   <= 1'b1;
            rsp_q <= '{rdata:   apb_write_out ? {APB_DATA_WIDTH{1'b0}} : apb_rdata_in,
                       slverr:  apb_slverr_in,
                       timeout: 1'b0};
          end else if (TMO_EN && wait_cnt == TMO) begin
            state           <= RESP;
            apb_psel_out    <= 1'b0;
            apb_penable_out <= 1'b0;
            rsp_valid_out   <= 1'b1;
            rsp_q           <= '{rdata: '0, slverr: 1'b1, timeout: 1'b1};
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready_in) begin
            state         <= IDLE;
            rsp_valid_out <= 1'b0;
            cmd_ready_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
